// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fsm
// Description : UART transmit controller that steps start, LSB-first data,
//               optional parity and stop bits one per clock.
//               Define UART_TX_PARITY_EN to enable the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ser_hold;
    logic                  w_load;

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_typ;
    logic r_par_hold;
    logic w_par_calc;
`else
    logic w_unused;
    assign w_unused = ^{PAR_EN, PAR_TYP};
`endif

    // Next-state logic; any encoding not listed falls back to IDLE
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    w_state_nxt = ST_START;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_nxt = ST_DATA;
                w_cnt_nxt   = '0;
            end
            ST_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
`else
                    w_state_nxt = ST_STOP;
`endif
                end else begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_state_nxt = ST_STOP;
`endif
            ST_STOP:   w_state_nxt = ST_IDLE;
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_ser_hold <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_data <= P_DATA;
            end
            if (r_state == ST_DATA) begin
                r_ser_hold <= r_data[r_cnt];
            end
        end
    end

    // Outputs track the current bit while selected and hold it afterwards
    assign ser_data = (r_state == ST_DATA) ? r_data[r_cnt] : r_ser_hold;
    assign busy     = (r_state != ST_IDLE);

    always_comb begin
        mux_sel = 2'b01;
        case (r_state)
            ST_START:  mux_sel = 2'b00;
            ST_DATA:   mux_sel = 2'b10;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: mux_sel = 2'b11;
`endif
            default:   mux_sel = 2'b01;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    assign w_par_calc = (^r_data) ^ r_par_typ;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_hold <= 1'b0;
        end else begin
            if (w_load) begin
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end
            if (r_state == ST_PARITY) begin
                r_par_hold <= w_par_calc;
            end
        end
    end

    assign par_bit = (r_state == ST_PARITY) ? w_par_calc : r_par_hold;
`else
    assign par_bit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fsm
// Description : Scoreboard bench for uart_tx_fsm against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fsm;

    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;

    typedef struct {
        logic [1:0] mux;
        logic       bsy;
        logic       bv;
    } beat_t;

    beat_t q[$];
    int    checks   = 0;
    int    failures = 0;
    int    n_accept = 0;
    logic  last_ser = 1'b0;
    logic  last_par = 1'b0;

    uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A frame is the list of line cycles it occupies, plus the mandatory idle gap
    function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        logic par_on;
        logic par;
`ifdef UART_TX_PARITY_EN
        par_on = pe;
`else
        par_on = 1'b0;
`endif
        par = logic'($countones(d) % 2) ^ pt;
        q.push_back('{2'b00, 1'b1, 1'b0});
        for (int i = 0; i < DW; i++) q.push_back('{2'b10, 1'b1, d[i]});
        if (par_on) q.push_back('{2'b11, 1'b1, par});
        q.push_back('{2'b01, 1'b1, 1'b0});
        q.push_back('{2'b01, 1'b0, 1'b0});
    endfunction

    always @(posedge CLK) begin
        if (RST && DATA_VALID && q.size() == 0) begin
            push_frame(P_DATA, PAR_EN, PAR_TYP);
            n_accept++;
        end
    end

    always @(negedge CLK) begin
        beat_t e;
        if (q.size() != 0) e = q.pop_front();
        else               e = '{2'b01, 1'b0, 1'b0};
        chk("mux_sel", 8'(mux_sel), 8'(e.mux));
        chk("busy", 8'(busy), 8'(e.bsy));
        if (e.mux == 2'b10) last_ser = e.bv;
        if (e.mux == 2'b11) last_par = e.bv;
        chk("ser_data", 8'(ser_data), 8'(last_ser));
        chk("par_bit", 8'(par_bit), 8'(last_par));
    end

    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
        int base;
        base = n_accept;
        @(negedge CLK);
        #1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 40 && n_accept == base; i++) begin
            @(posedge CLK);
            #1;
        end
        checks++;
        if (n_accept == base) begin
            failures++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance of %0h", d);
        end
        DATA_VALID = 1'b0;
        P_DATA     = DW'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
    endtask

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #1;
        chk("rst_mux", 8'(mux_sel), 8'h01);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_ser", 8'(ser_data), 8'h00);
        chk("rst_par", 8'(par_bit), 8'h00);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);

        send(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b1);
        send(8'h07, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b0);
        repeat (15) @(negedge CLK);

        // Request held high across several frames
        #1 DATA_VALID = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            #1;
            P_DATA  = DW'($urandom);
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
        end
        DATA_VALID = 1'b0;
        repeat (15) @(negedge CLK);

        // Asynchronous reset during the fourth data bit
        send(8'h3C, 1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        #2;
        RST = 1'b0;
        q.delete();
        last_ser = 1'b0;
        last_par = 1'b0;
        #1;
        chk("abort_mux", 8'(mux_sel), 8'h01);
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_ser", 8'(ser_data), 8'h00);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (6) @(negedge CLK);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            #1;
            DATA_VALID = ($urandom % 4 == 0);
            P_DATA     = DW'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
        end
        DATA_VALID = 1'b0;
        repeat (20) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
